// File: rtl/pixel_scan_pkg.sv
// pixel_scan_pkg: shared FSM states, word geometry and one-hot select decoding
// for pixel_scan_readout.
package pixel_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int FID_W = 4;
  localparam int OH_MAX = 256;
  typedef struct packed {
    logic       ok;
    logic [7:0] idx;
  } onehot_t;
  function automatic int word_w(int rows, int cols, int pix_w);
    return 1 + FID_W + $clog2(rows) + $clog2(cols) + pix_w;
  endfunction
  // idx is the lowest set bit; ok only when exactly one bit is set
  function automatic onehot_t onehot_idx(input logic [OH_MAX-1:0] v);
    onehot_t r;
    r.ok = v != '0 && (v & (v - OH_MAX'(1))) == '0;
    r.idx = '0;
    for (int i = OH_MAX - 1; i >= 0; i--) if (v[i]) r.idx = 8'(i);
    return r;
  endfunction
endpackage

// File: rtl/pixel_scan_readout_if.sv
// pixel_scan_readout_if: scan-stage sample inputs plus the outgoing word stream.
// master is the readout block, slave is the scan stage / serializer side.
interface pixel_scan_readout_if import pixel_scan_pkg::*; #(
  parameter int ROW_LENGTH    = 32,
  parameter int COLUMN_LENGTH = 8,
  parameter int PIX_WIDTH     = 4
);
  localparam int WORD_W = word_w(ROW_LENGTH, COLUMN_LENGTH, PIX_WIDTH);
  logic                     speak_o;
  logic                     marker_i;
  logic [ROW_LENGTH-1:0]    rowSel_i;
  logic [COLUMN_LENGTH-1:0] columnSel_i;
  logic [PIX_WIDTH-1:0]     pixData_i;
  logic [WORD_W-1:0]        data_o;
  logic                     valid_o;
  logic                     ready_i;
  modport master (output speak_o, data_o, valid_o,
                  input  marker_i, rowSel_i, columnSel_i, pixData_i, ready_i);
  modport slave  (input  speak_o, data_o, valid_o,
                  output marker_i, rowSel_i, columnSel_i, pixData_i, ready_i);
endinterface

// File: rtl/pixel_scan_fifo.sv
// pixel_scan_fifo: show-ahead FIFO; the head entry is presented directly and
// reads as zero while empty.
module pixel_scan_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_pop;
  assign o_valid = r_count != '0;
  assign w_pop   = i_pop && o_valid;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(i_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clock_i) if (i_push) r_mem[r_wr] <= i_data;
  a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
    !(i_push && !w_pop && r_count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/pixel_scan_readout.sv
// pixel_scan_readout: paces the pixel scan, encodes frame-tagged address/data words
// into a FIFO and streams them out. Define PIXEL_SCAN_ZS_EN for zero suppression.
module pixel_scan_readout import pixel_scan_pkg::*; #(
  parameter int ROW_LENGTH    = 32,
  parameter int COLUMN_LENGTH = 8,
  parameter int PIX_WIDTH     = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  output logic                 busy_o,
  output logic                 sel_err_o,
  pixel_scan_readout_if.master bus
);
  localparam int RB     = $clog2(ROW_LENGTH);
  localparam int CB     = $clog2(COLUMN_LENGTH);
  localparam int WORD_W = word_w(ROW_LENGTH, COLUMN_LENGTH, PIX_WIDTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  state_t                   r_state, w_next;
  logic                     r_s1_v, r_s1_mark, r_s2_v, r_sel_err;
  logic [ROW_LENGTH-1:0]    r_s1_row;
  logic [COLUMN_LENGTH-1:0] r_s1_col;
  logic [PIX_WIDTH-1:0]     r_s1_pix;
  logic [WORD_W-1:0]        r_s2_word;
  logic [FID_W-1:0]         r_fid, w_fid;
  logic [CW-1:0]            w_count;
  onehot_t                  w_row, w_col;
  logic                     w_ok, w_keep, w_speak, w_drained, w_unused;
  assign w_row     = onehot_idx(OH_MAX'(r_s1_row));
  assign w_col     = onehot_idx(OH_MAX'(r_s1_col));
  assign w_unused  = ^{w_row.idx[7:RB], w_col.idx[7:CB]};
  assign w_ok      = w_row.ok && w_col.ok;
`ifdef PIXEL_SCAN_ZS_EN
  assign w_keep    = w_ok && (r_s1_mark || r_s1_pix != '0);
`else
  assign w_keep    = w_ok;
`endif
  // the SOF word already carries the incremented frame id
  assign w_fid     = r_fid + FID_W'(r_s1_v && r_s1_mark);
  // credit counts every occupied pipeline stage, even one about to be dropped
  assign w_speak   = r_state == SCAN &&
                     (w_count + CW'(r_s1_v) + CW'(r_s2_v)) <= CW'(FIFO_DEPTH - 2);
  assign w_drained = !r_s1_v && !r_s2_v && w_count == '0;
  assign w_next    = enable_i ? SCAN :
                     (r_state == SCAN || (r_state == DRAIN && !w_drained)) ? DRAIN : IDLE;
  assign bus.speak_o = w_speak;
  assign busy_o      = r_state != IDLE;
  assign sel_err_o   = r_sel_err;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      r_state   <= IDLE;
      r_s1_v    <= 1'b0;
      r_s1_mark <= 1'b0;
      r_s1_row  <= '0;
      r_s1_col  <= '0;
      r_s1_pix  <= '0;
      r_s2_v    <= 1'b0;
      r_s2_word <= '0;
      r_fid     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_s1_v  <= w_speak;
      if (w_speak) begin
        r_s1_mark <= bus.marker_i;
        r_s1_row  <= bus.rowSel_i;
        r_s1_col  <= bus.columnSel_i;
        r_s1_pix  <= bus.pixData_i;
      end
      r_s2_v    <= r_s1_v && w_keep;
      r_s2_word <= {r_s1_mark, w_fid, w_row.idx[RB-1:0], w_col.idx[CB-1:0], r_s1_pix};
      r_fid     <= w_fid;
      if (r_s1_v && !w_ok) r_sel_err <= 1'b1;
    end
  pixel_scan_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .i_push  (r_s2_v),
    .i_data  (r_s2_word),
    .i_pop   (bus.ready_i),
    .o_data  (bus.data_o),
    .o_valid (bus.valid_o),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_pixel_scan_readout.sv
// tb_pixel_scan_readout: scan-stage model drives the readout; expected words go to
// a queue at capture time and a monitor pops and compares on every accepted word.
module tb_pixel_scan_readout;
  localparam int RL = 32, CL = 8, PW = 4, D = 8, NPIX = RL * CL, WW = 17;
  logic clock_i = 1'b0, reset_i = 1'b1, enable_i = 1'b0, busy_o, sel_err_o;
  pixel_scan_readout_if #(.ROW_LENGTH(RL), .COLUMN_LENGTH(CL), .PIX_WIDTH(PW)) bus ();
  pixel_scan_readout #(.ROW_LENGTH(RL), .COLUMN_LENGTH(CL), .PIX_WIDTH(PW), .FIFO_DEPTH(D)) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .busy_o    (busy_o),
    .sel_err_o (sel_err_o),
    .bus       (bus)
  );
  always #5 clock_i = ~clock_i;

  int n_vec = 0, n_err = 0, pos = 0, captures = 0, budget;
  logic [3:0] fid = '0, cur_pix = '0;
  logic [CL-1:0] bad_col = '0;
  bit en, rdy, rdy_rand, nz, zsp, chk_speak, chk_drain, injected, wrapped, seen;
  logic [WW-1:0] q[$];
  logic hold_v = 1'b0;
  logic [WW-1:0] hold_d;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] next_pix(int p);
    if (zsp) return p == 3 * CL + 5 ? 4'hA : 4'h0;
    return nz ? 4'($urandom_range(15, 1)) : 4'($urandom_range(15, 0));
  endfunction

  // one scan-stage cycle: present the current pixel, advance when speak_o is seen
  task automatic cycle();
    logic [WW-1:0] w;
    bit keep;
    @(negedge clock_i);
    enable_i = en;
    bus.ready_i = rdy_rand ? ($urandom_range(9, 0) < 7) : rdy;
    bus.rowSel_i = '0;
    bus.rowSel_i[pos / CL] = 1'b1;
    bus.columnSel_i = '0;
    bus.columnSel_i[pos % CL] = 1'b1;
    if (bad_col != '0) bus.columnSel_i = bad_col;
    bus.pixData_i = cur_pix;
    bus.marker_i = pos == 0;
    #1;
    if (chk_speak) chk("speak_credit", 32'(bus.speak_o), 32'(q.size() <= D - 2));
    if (chk_drain) begin
      chk("drain_speak", 32'(bus.speak_o), 0);
      chk("drain_busy", 32'(busy_o), 1);
    end
    if (bus.speak_o) begin
      if (pos == 0) begin
        fid++;
        if (fid == 4'd0) wrapped = 1'b1;
      end
      w = {pos == 0, fid, 5'(pos / CL), 3'(pos % CL), cur_pix};
      keep = bad_col == '0;
`ifdef PIXEL_SCAN_ZS_EN
      keep = keep && (pos == 0 || cur_pix != 4'h0);
`endif
      if (keep) q.push_back(w);
      injected = bad_col != '0;
      bad_col = '0;
      captures++;
      pos = (pos + 1) % NPIX;
      cur_pix = next_pix(pos);
    end
  endtask

  always @(negedge clock_i) begin
    logic [WW-1:0] exp;
    #2;
    if (!reset_i && bus.valid_o && bus.ready_i) begin
      if (q.size() == 0) chk("unexpected_word", 32'(bus.data_o), 0);
      else begin
        exp = q.pop_front();
        chk("word", 32'(bus.data_o), 32'(exp));
      end
    end
    if (!reset_i && hold_v) chk("hold_stable", 32'({bus.valid_o, bus.data_o}), 32'({1'b1, hold_d}));
    hold_v = !reset_i && bus.valid_o && !bus.ready_i;
    hold_d = bus.data_o;
  end

  initial begin
    bus.ready_i = 1'b0; bus.marker_i = 1'b0; bus.rowSel_i = '0; bus.columnSel_i = '0; bus.pixData_i = '0;
    cur_pix = next_pix(0);
    #12;
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_speak", 32'(bus.speak_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_sel_err", 32'(sel_err_o), 0);
    chk("rst_data", 32'(bus.data_o), 0);
    @(negedge clock_i) reset_i = 1'b0;
    en = 1; rdy_rand = 1;
    budget = 4000;
    while (captures < 2 * NPIX + 20 && budget-- > 0) cycle();
    if (budget <= 0) chk("timeout_frames", 0, 1);
    // stall: credit must stop the scan before the FIFO can overflow
    nz = 1; cur_pix = next_pix(pos); rdy_rand = 0; rdy = 0;
    repeat (3) cycle();
    chk_speak = 1;
    repeat (25) cycle();
    chk_speak = 0;
    chk("stall_speak_off", 32'(bus.speak_o), 0);
    rdy = 1; seen = 0;
    repeat (20) begin cycle(); seen |= bus.speak_o; end
    chk("speak_resume", 32'(seen), 1);
    nz = 0;
    // malformed column select
    chk("sel_err_clear", 32'(sel_err_o), 0);
    bad_col = 8'h03; injected = 0; budget = 50;
    while (!injected && budget-- > 0) cycle();
    if (!injected) chk("timeout_inject", 0, 1);
    cycle(); chk("sel_err_early", 32'(sel_err_o), 0);
    cycle(); chk("sel_err_set", 32'(sel_err_o), 1);
    // sparse frame for zero suppression
    rdy_rand = 1; budget = 2000;
    while (pos != 0 && budget-- > 0) cycle();
    zsp = 1; cur_pix = next_pix(pos); cycle(); budget = 2000;
    while (pos != 0 && budget-- > 0) cycle();
    if (budget <= 0) chk("timeout_zs_frame", 0, 1);
    zsp = 0; cur_pix = next_pix(pos);
    // drop enable mid-frame and drain
    repeat (100) cycle();
    en = 0; cycle(); chk_drain = 1; budget = 200;
    while (q.size() != 0 && budget-- > 0) cycle();
    chk_drain = 0;
    if (budget <= 0) chk("timeout_drain", 0, 1);
    repeat (3) cycle();
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_valid", 32'(bus.valid_o), 0);
    chk("idle_speak", 32'(bus.speak_o), 0);
    // reset while SCAN holds buffered words
    en = 1; rdy_rand = 0; rdy = 0; budget = 50;
    while (q.size() != 7 && budget-- > 0) cycle();
    if (budget <= 0) chk("timeout_fill", 0, 1);
    @(negedge clock_i);
    #3 reset_i = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.valid_o), 0);
    chk("midrst_speak", 32'(bus.speak_o), 0);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_sel_err", 32'(sel_err_o), 0);
    q.delete(); pos = 0; fid = '0; wrapped = 0; cur_pix = next_pix(0);
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    // long run across the frame id wrap
    rdy_rand = 1; budget = 14000;
    while (!(wrapped && pos > 10) && budget-- > 0) cycle();
    if (budget <= 0) chk("timeout_wrap", 0, 1);
    en = 0; budget = 300;
    while ((q.size() != 0 || busy_o) && budget-- > 0) cycle();
    chk("final_queue_empty", 32'(q.size()), 0);
    chk("final_busy", 32'(busy_o), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
